// File: rtl/counter_summer_pkg.sv
// +------------------------------------------------------------------+
// | counter_summer_pkg: shared state type and default widths.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package counter_summer_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int SUM_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_summer_up_counter.sv
// +------------------------------------------------------------------+
// | up_counter: CNT_W-bit synchronous counter, one D flop per bit.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module up_counter
  import counter_summer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_d;
  logic [CNT_W-1:0] incr;

  assign incr = value + CNT_W'(1);

  // clr dominates en so the parent can restart while a run is stepping
  always_comb begin
    value_d = value;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = incr;
    end
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_bit
    logic bit_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bit_q <= 1'b0;
      end else begin
        bit_q <= value_d[i];
      end
    end

    assign value[i] = bit_q;
  end

endmodule

`default_nettype wire

// File: rtl/counter_summer.sv
// +------------------------------------------------------------------+
// | counter_summer: counts 0..limit and returns the running sum.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module counter_summer
  import counter_summer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = 2 * CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] limit,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [SUM_W-1:0] sum
);

  state_e           state_q;
  logic [CNT_W-1:0] lim_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic             busy_q;
  logic             done_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_limit;

  assign at_limit = (count == lim_q);
  assign sum_d    = sum_q + SUM_W'(count);

  // Counter control follows the current state; every accepted start or ack clears it
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: cnt_clr = 1'b1;
      ST_RUN:  cnt_en  = !at_limit;
      ST_DONE: cnt_clr = start | ack;
      default: cnt_clr = 1'b1;
    endcase
  end

  up_counter #(
    .CNT_W (CNT_W)
  ) u_up_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .value (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lim_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sum_q <= '0;
          if (start) begin
            state_q <= ST_RUN;
            lim_q   <= limit;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_q <= sum_d;
          if (at_limit) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            lim_q   <= limit;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else if (ack) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sum_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_summer.sv
// +------------------------------------------------------------------+
// | tb_counter_summer: scoreboard bench for counter_summer.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_counter_summer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack   = 1'b0;
  logic [3:0] limit = 4'd0;
  logic       busy, done, busy4, done4;
  logic [3:0] count, count4;
  logic [7:0] sum;
  logic [3:0] sum4;

  counter_summer #(.CNT_W(4), .SUM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .ack(ack),
    .busy(busy), .done(done), .count(count), .sum(sum)
  );

  // Narrow-accumulator copy driven by the same stimulus: sums wrap mod 16
  counter_summer #(.CNT_W(4), .SUM_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .ack(ack),
    .busy(busy4), .done(done4), .count(count4), .sum(sum4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lim;
    int t0;
  } run_t;

  run_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int L, bit with_ack);
    start = 1'b1;
    ack   = with_ack;
    limit = 4'(L);
    sb.push_back('{lim: L, t0: cyc + 1});
    tick();
    start = 1'b0;
    ack   = 1'b0;
    limit = 4'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) tick();
    check("done_timeout", int'(done), 1);
  endtask

  task automatic check_idle(string nm);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_done"}, int'(done), 0);
    check({nm, "_count"}, int'(count), 0);
    check({nm, "_sum"}, int'(sum), 0);
  endtask

  // Monitor: per-cycle count trace during a run, and result check on done rise
  always @(negedge clk) begin
    run_t r;
    if (rst_n) begin
      check("busy_done_excl", int'(busy & done), 0);
      if (busy && sb.size() > 0)
        check("run_count", int'(count), cyc - sb[0].t0);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          r = sb.pop_front();
          check("sum", int'(sum), (r.lim * (r.lim + 1) / 2) % 256);
          check("sum_w4", int'(sum4), (r.lim * (r.lim + 1) / 2) % 16);
          check("final_count", int'(count), r.lim);
          check("latency", cyc - r.t0, r.lim + 1);
        end
      end
    end
    done_prev = done;
  end

  initial begin
    int L;
    bit a;
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    check("reset_sum4", int'(sum4), 0);
    rst_n = 1'b1;
    tick();

    // limit=4: sum 10, held in DONE, cleared by ack
    issue(4, 1'b0);
    wait_done();
    tick();
    tick();
    check("hold_sum", int'(sum), 10);
    check("hold_count", int'(count), 4);
    check("hold_done", int'(done), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_idle("after_ack");

    // limit=0 edge case
    issue(0, 1'b0);
    wait_done();
    check("lim0_sum", int'(sum), 0);
    ack = 1'b1; tick(); ack = 1'b0;

    // full range: 120 (and 8 in the 4-bit accumulator)
    issue(15, 1'b0);
    wait_done();
    check("lim15_sum", int'(sum), 120);
    check("lim15_sum4", int'(sum4), 8);
    ack = 1'b1; tick(); ack = 1'b0;

    // start with a new limit mid-run is ignored
    issue(5, 1'b0);
    tick();
    start = 1'b1; limit = 4'd2;
    tick();
    start = 1'b0;
    wait_done();
    check("midstart_sum", int'(sum), 15);
    ack = 1'b1; tick(); ack = 1'b0;

    // reset pulse in the middle of a run
    issue(7, 1'b0);
    for (int i = 0; i < 20 && count != 4'd3; i++) tick();
    check("reach_count3", int'(count), 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check_idle("midrun_reset");
    issue(3, 1'b0);
    wait_done();
    check("post_reset_sum", int'(sum), 6);
    ack = 1'b1; tick(); ack = 1'b0;

    // restart directly from DONE without ack
    issue(4, 1'b0);
    wait_done();
    check("pre_restart_sum", int'(sum), 10);
    issue(3, 1'b0);
    check("restart_done_drop", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    wait_done();
    check("restart_sum", int'(sum), 6);
    ack = 1'b1; tick(); ack = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    check_idle("ack_in_idle");

    // randomized runs: mixed ack, restart-from-DONE and ignored mid-run starts
    for (int k = 0; k < 25; k++) begin
      L = int'($urandom_range(0, 15));
      a = 1'($urandom_range(0, 1));
      issue(L, a);
      if (L > 2 && $urandom_range(0, 1) == 1) begin
        tick();
        start = 1'b1;
        limit = 4'($urandom);
        tick();
        start = 1'b0;
      end
      wait_done();
      if ($urandom_range(0, 2) == 0) begin
        ack = 1'b1; tick(); ack = 1'b0;
      end
    end

    ack = 1'b1; tick(); ack = 1'b0;
    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/counter_summer.md
# counter_summer

Sequential up-counter with a running-sum accumulator, the stage directly downstream of the team's D flip-flop cell. The flip-flop provides single-bit storage; this block composes that storage into a CNT_W-bit counter that steps from 0 to a latched limit. Every count value is added into a SUM_W-bit accumulator. A start/done/ack handshake returns the result 0+1+…+limit.

## Interface
- CNT_W, default 4: counter and limit width.
- SUM_W, default 2*CNT_W: accumulator width. Exact result requires SUM_W ≥ 2*CNT_W−1; any smaller value wraps modulo 2^SUM_W.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a summation; sampled only in IDLE and DONE.
- limit  in  CNT_W  final count value; latched on the accepted start.
- ack  in  1  consumer has taken the result; sampled only in DONE.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; result valid.
- count  out  CNT_W  current counter value.
- sum  out  SUM_W  accumulator value.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - count=0, sum=0, busy=0, done=0.
  - start=1 latches limit into lim_q and goes to RUN with count=0, sum=0.
- RUN, each cycle:
  - sum ← sum + zero-extended count, modulo 2^SUM_W.
  - If count==lim_q, go to DONE and hold count at lim_q.
  - Otherwise count ← count+1.
- DONE:
  - done=1; sum and count hold.
  - ack=1 goes to IDLE, clearing count and sum.
  - start=1, with or without ack, restarts directly: latch the new limit, go to RUN with count=0, sum=0.
- Ignored inputs:
  - start is ignored in RUN; the in-flight limit is unaffected.
  - ack is ignored in IDLE and RUN.
  - Changes to limit outside an accepted start have no effect.
- Counter never wraps, because it stops at lim_q ≤ 2^CNT_W−1.
- limit=0: one RUN cycle adds 0, then DONE with sum=0.
- Reset:
  - rst_n=0 at any edge, including mid-RUN, forces IDLE, count=0, sum=0, lim_q=0, busy=0, done=0.
  - rst_n has priority over start and ack.
- Illegal state encodings recover to IDLE.

## Timing
- Reset values: busy=0, done=0, count=0, sum=0.
- Start accepted at edge E0:
  - busy=1 from E0.
  - RUN lasts limit+1 cycles.
  - done=1 from edge E0+limit+1.
  - Latency from start to done: limit+1 cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- busy and done are never high together.
- Throughput: a start issued in the same cycle done is first seen gives back-to-back runs with no IDLE gap.

## Structure
- Shared package counter_summer_pkg:
  - state typedef: IDLE, RUN, DONE (2-bit encoding).
  - default width constants CNT_W_DEF=4 and SUM_W_DEF=8.
- One sub-module, up_counter:
  - CNT_W-bit synchronous counter.
  - inputs clr and en; output value.
  - built from the team's D flip-flop storage.
- FSM, lim_q register and accumulator live in the top level.

## Test plan
- Reset, then limit=4 with a start pulse: busy for exactly 5 cycles, count steps 0,1,2,3,4; done rises 5 cycles after the start edge with sum=10 held; ack returns to IDLE with sum=0.
- limit=0: single RUN cycle, done=1 with sum=0 and count=0.
- CNT_W=4, limit=15: sum=120 after 16 RUN cycles. Rerun with SUM_W=4: sum=8 (120 mod 16).
- Start pulse and limit=2 asserted mid-RUN of a limit=5 run: ignored; final sum=15 and run length is 6 cycles.
- rst_n=0 for one cycle at count=3 of a limit=7 run: next cycle IDLE, count=0, sum=0, busy=0, done=0. A subsequent limit=3 run gives sum=6.
- In DONE with sum=10, start with limit=3 and no ack: immediate RUN, done drops, final sum=6; ack in IDLE has no effect.
